// File: rtl/spi_tx_serializer_if.sv
// Handshake and serial-line bundle for spi_tx_serializer.
// The master side feeds words and the bit strobe, and the slave side is the serializer.
interface spi_tx_serializer_if #(
    parameter int unsigned NUM_BITS = 8
);
    logic [NUM_BITS-1:0] data_in;
    logic                data_valid;
    logic                data_ready;
    logic                lsb_first;
    logic                shift_enable;
    logic                serial_out;
    logic                busy;
    logic                word_done;

    modport master (
        output data_in,
        output data_valid,
        output lsb_first,
        output shift_enable,
        input  data_ready,
        input  serial_out,
        input  busy,
        input  word_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  lsb_first,
        input  shift_enable,
        output data_ready,
        output serial_out,
        output busy,
        output word_done
    );
endinterface

// File: rtl/spi_tx_serializer.sv
// Buffered parallel-to-serial transmitter. Words are queued in a small FIFO and
// shifted out one bit per shift_enable strobe, MSB- or LSB-first per word.
module spi_tx_serializer #(
    parameter int unsigned NUM_BITS   = 8,
    parameter int unsigned DEPTH      = 2,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    spi_tx_serializer_if.slave    bus
);

    localparam int unsigned ENTRY_W = NUM_BITS + 1;
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned BCNT_W  = $clog2(NUM_BITS);

    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(NUM_BITS - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // ---------------- FIFO ----------------
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign bus.data_ready = (count_q != CNT_FULL);
    assign push           = bus.data_valid && bus.data_ready;
    assign fifo_empty     = (count_q == '0);
    assign head           = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.lsb_first, bus.data_in};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- Shifter FSM ----------------
    logic                state_q, state_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic                mode_q, mode_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                serial_q, serial_d;
    logic                word_done_q, word_done_d;
    logic                load;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        mode_d      = mode_q;
        bit_cnt_d   = bit_cnt_q;
        serial_d    = serial_q;
        word_done_d = 1'b0;
        load        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serial_d = IDLE_LEVEL;
                load     = !fifo_empty;
            end
            ST_SHIFT: begin
                if (bus.shift_enable) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        shreg_d   = mode_q ? (shreg_q >> 1) : (shreg_q << 1);
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                        serial_d  = mode_q ? shreg_q[1] : shreg_q[NUM_BITS-2];
                    end else begin
                        word_done_d = 1'b1;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d   = ST_IDLE;
                            serial_d  = IDLE_LEVEL;
                            shreg_d   = '0;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = IDLE_LEVEL;
            end
        endcase

        // Shared by IDLE and the last-bit strobe so streaming loads the next word on the same edge.
        if (load) begin
            pop       = 1'b1;
            state_d   = ST_SHIFT;
            shreg_d   = head[NUM_BITS-1:0];
            mode_d    = head[NUM_BITS];
            bit_cnt_d = '0;
            serial_d  = head[NUM_BITS] ? head[0] : head[NUM_BITS-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            mode_q      <= 1'b0;
            bit_cnt_q   <= '0;
            serial_q    <= IDLE_LEVEL;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            serial_q    <= serial_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.serial_out = serial_q;
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.word_done  = word_done_q;

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Scoreboard bench for spi_tx_serializer: expected bits are queued at push and
// compared as each bit is strobed off the line.
module tb_spi_tx_serializer;

    localparam int unsigned NB = 8;

    logic clk;
    logic n_rst;
    int   strobe_period;

    spi_tx_serializer_if #(.NUM_BITS(NB)) bus ();

    spi_tx_serializer #(
        .NUM_BITS   (NB),
        .DEPTH      (2),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic exp_q[$];
    int   done_cyc[$];
    int   cyc         = 0;
    int   bits_seen   = 0;
    int   done_cnt    = 0;
    int   busy_cycles = 0;
    int   first_busy  = -1;
    int   last_busy   = -1;
    int   idle_bad    = 0;
    logic prev_done   = 1'b0;
    logic saw_not_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        int sdiv;
        sdiv = 0;
        bus.shift_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (strobe_period <= 0) begin
                bus.shift_enable = 1'b0;
                sdiv = 0;
            end else if (sdiv >= strobe_period - 1) begin
                bus.shift_enable = 1'b1;
                sdiv = 0;
            end else begin
                bus.shift_enable = 1'b0;
                sdiv++;
            end
        end
    end

    // A bit is consumed when a strobe is pending at the next edge while busy.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.busy) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
            end else if (bus.serial_out !== 1'b1) begin
                idle_bad++;
            end
            if (bus.busy && bus.shift_enable) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(bus.serial_out), 32'hDEAD);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    check("bit", 32'(bus.serial_out), 32'(e));
                    bits_seen++;
                end
            end
            if (bus.word_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                check("done_width", 32'(prev_done), 32'd0);
            end
            prev_done = bus.word_done;
        end
    end

    task automatic push_word(input logic [NB-1:0] d, input logic lsb);
        int waited;
        waited = 0;
        bus.data_in    = d;
        bus.lsb_first  = lsb;
        bus.data_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.data_ready) break;
            saw_not_ready = 1'b1;
            waited++;
            if (waited > 200) begin
                check("push_ready", 32'(bus.data_ready), 32'd1);
                bus.data_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            exp_q.push_back(lsb ? d[i] : d[NB-1-i]);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy || exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                check("idle_timeout", 32'(bus.busy), 32'd0);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_stats();
        busy_cycles = 0;
        first_busy  = -1;
        last_busy   = -1;
        done_cyc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int idle_base;
        int n;
        n_rst          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.lsb_first  = 1'b0;
        strobe_period  = 0;
        saw_not_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_serial", 32'(bus.serial_out), 32'd1);
        check("rst_busy",   32'(bus.busy),       32'd0);
        check("rst_done",   32'(bus.word_done),  32'd0);
        check("rst_ready",  32'(bus.data_ready), 32'd1);
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // MSB-first, strobe every 4 clk
        strobe_period = 4;
        base = done_cnt;
        push_word(8'h1E, 1'b0);
        @(negedge clk);
        check("lat_busy_e1", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("lat_busy_e2", 32'(bus.busy), 32'd1);
        check("lat_bit0",    32'(bus.serial_out), 32'd0);
        wait_idle(200);
        check("msb_done", 32'(done_cnt - base), 32'd1);
        check("msb_idle", 32'(bus.serial_out), 32'd1);
        check("msb_sb",   32'(exp_q.size()), 32'd0);

        // LSB-first with lsb_first toggling during transmission
        @(posedge clk);
        #1;
        base = done_cnt;
        push_word(8'h1E, 1'b1);
        repeat (16) begin
            @(posedge clk);
            #1 bus.lsb_first = ~bus.lsb_first;
        end
        wait_idle(200);
        check("lsb_done", 32'(done_cnt - base), 32'd1);
        check("lsb_sb",   32'(exp_q.size()), 32'd0);

        // Streaming with held strobe and backpressure
        @(posedge clk);
        #1;
        strobe_period = 1;
        saw_not_ready = 1'b0;
        clear_stats();
        base = done_cnt;
        push_word(8'h81, 1'b0);
        push_word(8'h42, 1'b0);
        push_word(8'h24, 1'b0);
        push_word(8'hFF, 1'b0);
        wait_idle(200);
        check("strm_backpressure", 32'(saw_not_ready), 32'd1);
        check("strm_busy_cycles",  32'(busy_cycles), 32'd32);
        check("strm_contiguous",   32'(last_busy - first_busy + 1), 32'd32);
        check("strm_done",         32'(done_cnt - base), 32'd4);
        check("strm_done_q",       32'(done_cyc.size()), 32'd4);
        for (int i = 1; i < done_cyc.size(); i++) begin
            check("strm_done_gap", 32'(done_cyc[i] - done_cyc[i-1]), 32'd8);
        end

        // Strobes with an empty FIFO
        @(posedge clk);
        #1;
        strobe_period = 2;
        clear_stats();
        base      = done_cnt;
        idle_base = idle_bad;
        repeat (40) @(posedge clk);
        #1;
        check("idle_busy",   32'(busy_cycles), 32'd0);
        check("idle_done",   32'(done_cnt - base), 32'd0);
        check("idle_level",  32'(idle_bad - idle_base), 32'd0);
        check("idle_serial", 32'(bus.serial_out), 32'd1);

        // Reset after three bits of 0x5A, then recover with 0x0F
        base = bits_seen;
        push_word(8'h5A, 1'b0);
        n = 0;
        while (bits_seen < base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_bits", 32'(bits_seen - base), 32'd3);
        @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_serial", 32'(bus.serial_out), 32'd1);
        check("mid_rst_busy",   32'(bus.busy),       32'd0);
        check("mid_rst_done",   32'(bus.word_done),  32'd0);
        check("mid_rst_ready",  32'(bus.data_ready), 32'd1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        clear_stats();
        base = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy_cycles), 32'd0);
        check("post_rst_done", 32'(done_cnt - base), 32'd0);
        push_word(8'h0F, 1'b0);
        wait_idle(200);
        check("rec_done", 32'(done_cnt - base), 32'd1);
        check("rec_sb",   32'(exp_q.size()), 32'd0);
        check("idle_level_all", 32'(idle_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
